// File: rtl/id_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_stage_pkg
// Shared definitions for the RV32I decode stage: register-index width,
// the base-ISA major opcodes, the immediate-format enumeration, and a
// helper that maps an opcode onto its immediate format.
// ---------------------------------------------------------------------------
package id_stage_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // R-type and unrecognised opcodes carry no immediate.
    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Combinational RV32I immediate decoder. Extracts the I/S/B/U/J immediate
// from an instruction word and sign-extends it to N bits; yields 0 for
// R-type and unknown opcodes.
//   instr  in  32  instruction word
//   imm    out N   sign-extended immediate
// ---------------------------------------------------------------------------
module imm_gen
    import id_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [31:0]  instr,
    output logic [N-1:0] imm
);

    imm_fmt_e    fmt;
    logic [31:0] imm32;

    always_comb begin
        fmt   = imm_fmt_of(instr[6:0]);
        imm32 = 32'd0;
        case (fmt)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'd0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    // Sign-extending cast: bit 31 of the 32-bit form is the sign for every format.
    assign imm = N'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// RV32I instruction-decode stage with a register scoreboard, write-back
// operand bypass and a single output register toward execute.
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc/if_ready  fetch handshake and payload
//   rf_rs1/rf_rs2, rf_rdata1/2      register file read addresses / data
//   wb_we/wb_rd/wb_data             write-back port (also writes the RF)
//   flush                           drop held instruction, clear scoreboard
//   ex_valid/ex_ready               execute handshake
//   ex_pc/ex_instr/ex_rs1_data/ex_rs2_data/ex_imm/ex_rd/ex_rd_we  payload
// ---------------------------------------------------------------------------
module id_stage
    import id_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid,
    input  logic [31:0]          if_instr,
    input  logic [N-1:0]         if_pc,
    output logic                 if_ready,
    output logic [REG_IDX_W-1:0] rf_rs1,
    output logic [REG_IDX_W-1:0] rf_rs2,
    input  logic [N-1:0]         rf_rdata1,
    input  logic [N-1:0]         rf_rdata2,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [N-1:0]         wb_data,
    input  logic                 flush,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [N-1:0]         ex_pc,
    output logic [31:0]          ex_instr,
    output logic [N-1:0]         ex_rs1_data,
    output logic [N-1:0]         ex_rs2_data,
    output logic [N-1:0]         ex_imm,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic                 ex_rd_we
);

    logic [6:0]           opcode;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 uses_rs1;
    logic                 uses_rs2;
    logic                 rd_we;
    logic                 hazard;
    logic                 accept;
    logic [N-1:0]         imm;
    logic [N-1:0]         rs1_data;
    logic [N-1:0]         rs2_data;
    logic [31:0]          busy_reg;
    logic [31:0]          busy_next;

    assign opcode = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];
    assign rf_rs1 = rs1;
    assign rf_rs2 = rs2;

    // Register usage classification by major opcode.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        rd_we    = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: rd_we = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                uses_rs1 = 1'b1;
                rd_we    = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                rd_we    = 1'b1;
            end
            default: ;
        endcase
        // x0 is never a real destination.
        if (rd == '0) begin
            rd_we = 1'b0;
        end
    end

    imm_gen #(.N(N)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // A register whose write is retiring this very cycle is no longer a
    // hazard: its value arrives through the bypass below.
    always_comb begin
        hazard = 1'b0;
        if (uses_rs1 && busy_reg[rs1] && !(wb_we && wb_rd == rs1)) hazard = 1'b1;
        if (uses_rs2 && busy_reg[rs2] && !(wb_we && wb_rd == rs2)) hazard = 1'b1;
        if (rd_we    && busy_reg[rd]  && !(wb_we && wb_rd == rd))  hazard = 1'b1;
    end

    assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
    assign accept   = if_valid && if_ready;

    // Operand bypass from write-back; x0 always reads as zero.
    always_comb begin
        rs1_data = rf_rdata1;
        rs2_data = rf_rdata2;
        if (rs1 == '0)                  rs1_data = '0;
        else if (wb_we && wb_rd == rs1) rs1_data = wb_data;
        if (rs2 == '0)                  rs2_data = '0;
        else if (wb_we && wb_rd == rs2) rs2_data = wb_data;
    end

    // Scoreboard next state, one bit per architectural register. A set from
    // an accept beats a clear from write-back on the same register.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = accept && rd_we && (rd == REG_IDX_W'(gi));
            assign clr_bit = wb_we && (wb_rd == REG_IDX_W'(gi));
            assign busy_next[gi] = !flush && (set_bit || (busy_reg[gi] && !clr_bit));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Output register toward execute; payload only changes on an accept,
    // so it stays stable while execute is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_instr    <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rd_we    <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_instr    <= if_instr;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= imm;
            ex_rd       <= rd;
            ex_rd_we    <= rd_we;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
// Directed self-checking bench for id_stage. Inputs change 1 ns after a
// rising edge; combinational outputs are checked 1 ns after that and
// registered outputs 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_id_stage;

    localparam int N = 32;

    localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD_X3     = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADDI_X4_1  = 32'h0010_0213; // addi x4,x0,1
    localparam logic [31:0] I_LW_X0      = 32'h0041_2003; // lw   x0,4(x2)
    localparam logic [31:0] I_SW_X5      = 32'hFE51_2C23; // sw   x5,-8(x2)
    localparam logic [31:0] I_BEQ_M2     = 32'hFE00_0FE3; // beq  x0,x0,-2
    localparam logic [31:0] I_JAL_2048   = 32'h0010_006F; // jal  x0,+2048
    localparam logic [31:0] I_LUI_X6     = 32'h1234_5337; // lui  x6,0x12345
    localparam logic [31:0] I_ADDI_X7_7  = 32'h0070_0393; // addi x7,x0,7

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         if_valid = 1'b0;
    logic [31:0]  if_instr = '0;
    logic [N-1:0] if_pc = '0;
    logic         if_ready;
    logic [4:0]   rf_rs1, rf_rs2;
    logic [N-1:0] rf_rdata1 = '0;
    logic [N-1:0] rf_rdata2 = '0;
    logic         wb_we = 1'b0;
    logic [4:0]   wb_rd = '0;
    logic [N-1:0] wb_data = '0;
    logic         flush = 1'b0;
    logic         ex_valid;
    logic         ex_ready = 1'b0;
    logic [N-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [31:0]  ex_instr;
    logic [4:0]   ex_rd;
    logic         ex_rd_we;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    id_stage #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_pc       (ex_pc),
        .ex_instr    (ex_instr),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_rd       (ex_rd),
        .ex_rd_we    (ex_rd_we)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [N-1:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ex_valid"}, ex_valid, 0);
        check_val({tag, "_busy"}, dut.busy_reg, 0);
        check_val({tag, "_payload"},
                  ex_pc | ex_instr | ex_rs1_data | ex_rs2_data | ex_imm |
                  N'(ex_rd) | N'(ex_rd_we), 0);
    endtask

    initial begin
        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        #18 rst_n = 1'b1;          // released between edges
        tick();

        // ---------------- ADDI x1,x0,5 ----------------
        present(I_ADDI_X1_5, 32'h100);
        ex_ready = 1'b1;
        #1;
        check_val("addi_if_ready", if_ready, 1);
        check_val("addi_rf_rs1", rf_rs1, 0);
        check_val("addi_rf_rs2", rf_rs2, 5);
        tick();
        check_val("addi_ex_valid", ex_valid, 1);
        check_val("addi_ex_imm", ex_imm, 5);
        check_val("addi_ex_rd", ex_rd, 1);
        check_val("addi_ex_rd_we", ex_rd_we, 1);
        check_val("addi_ex_pc", ex_pc, 32'h100);
        check_val("addi_busy", dut.busy_reg, 32'h2);

        // ---------------- RAW on x1, resolved by write-back ----------------
        present(I_ADD_X3, 32'h104);
        rf_rdata1 = 32'h11;
        rf_rdata2 = 32'h22;
        #1 check_val("raw_stall_if_ready", if_ready, 0);
        tick();
        check_val("raw_bubble_ex_valid", ex_valid, 0);
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        #1 check_val("raw_wb_if_ready", if_ready, 1);
        tick();
        check_val("raw_ex_valid", ex_valid, 1);
        check_val("raw_ex_rs1_bypass", ex_rs1_data, 32'h55);
        check_val("raw_ex_rs2_data", ex_rs2_data, 32'h22);
        check_val("raw_ex_rd", ex_rd, 3);
        check_val("raw_ex_imm_rtype", ex_imm, 0);
        check_val("raw_busy", dut.busy_reg, 32'h8);
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        // ---------------- execute back-pressure ----------------
        ex_ready = 1'b0;
        present(I_ADDI_X4_1, 32'h108);
        for (int i = 0; i < 3; i++) begin
            #1 check_val("bp_if_ready", if_ready, 0);
            tick();
            check_val("bp_ex_valid", ex_valid, 1);
            check_val("bp_ex_pc", ex_pc, 32'h104);
            check_val("bp_ex_instr", ex_instr, I_ADD_X3);
        end
        ex_ready = 1'b1;
        #1 check_val("bp_release_if_ready", if_ready, 1);
        tick();
        check_val("bp_next_ex_valid", ex_valid, 1);
        check_val("bp_next_ex_pc", ex_pc, 32'h108);
        check_val("bp_next_ex_imm", ex_imm, 1);
        check_val("bp_busy", dut.busy_reg, 32'h18);

        // ---------------- LW x0 / SW ----------------
        present(I_LW_X0, 32'h10C);
        rf_rdata1 = 32'h1000;
        tick();
        check_val("lw_ex_rd_we", ex_rd_we, 0);
        check_val("lw_ex_imm", ex_imm, 4);
        check_val("lw_ex_rs1", ex_rs1_data, 32'h1000);
        check_val("lw_busy", dut.busy_reg, 32'h18);
        present(I_SW_X5, 32'h110);
        rf_rdata2 = 32'hABCD;
        tick();
        check_val("sw_ex_imm", ex_imm, 32'hFFFF_FFF8);
        check_val("sw_ex_rd_we", ex_rd_we, 0);
        check_val("sw_ex_rs2", ex_rs2_data, 32'hABCD);
        check_val("sw_busy", dut.busy_reg, 32'h18);

        // ---------------- retire x3 and x4 ----------------
        if_valid = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd3;
        tick();
        wb_rd = 5'd4;
        tick();
        wb_we = 1'b0; wb_rd = '0;
        check_val("retire_busy", dut.busy_reg, 0);
        check_val("retire_ex_valid", ex_valid, 0);

        // ---------------- WAW on x4 ----------------
        present(I_ADDI_X4_1, 32'h200);
        tick();
        check_val("waw_first_busy", dut.busy_reg, 32'h10);
        present(I_ADDI_X4_1, 32'h204);
        #1 check_val("waw_stall_if_ready", if_ready, 0);
        tick();
        check_val("waw_bubble_ex_valid", ex_valid, 0);
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h1;
        #1 check_val("waw_wb_if_ready", if_ready, 1);
        tick();
        check_val("waw_ex_pc", ex_pc, 32'h204);
        check_val("waw_set_wins_busy", dut.busy_reg, 32'h10);
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        // ---------------- remaining immediate formats ----------------
        present(I_BEQ_M2, 32'h208);
        tick();
        check_val("beq_ex_imm", ex_imm, 32'hFFFF_FFFE);
        check_val("beq_ex_rd_we", ex_rd_we, 0);
        present(I_JAL_2048, 32'h20C);
        tick();
        check_val("jal_ex_imm", ex_imm, 32'h800);
        present(I_LUI_X6, 32'h210);
        tick();
        check_val("lui_ex_imm", ex_imm, 32'h1234_5000);
        check_val("lui_busy", dut.busy_reg, 32'h50);

        // ---------------- x0 operand never bypassed ----------------
        present(I_ADDI_X7_7, 32'h214);
        rf_rdata1 = 32'h77;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h99;
        tick();
        check_val("x0_ex_rs1", ex_rs1_data, 0);
        check_val("x0_busy", dut.busy_reg, 32'hD0);
        wb_we = 1'b0; wb_data = '0;

        // ---------------- flush ----------------
        present(I_ADDI_X1_5, 32'h300);
        flush = 1'b1;
        #1 check_val("flush_if_ready", if_ready, 0);
        tick();
        flush = 1'b0;
        check_val("flush_ex_valid", ex_valid, 0);
        check_val("flush_busy", dut.busy_reg, 0);

        // ---------------- async reset during a stall ----------------
        ex_ready = 1'b0;
        present(I_ADDI_X1_5, 32'h400);
        tick();
        check_val("stall_ex_valid", ex_valid, 1);
        present(I_ADDI_X4_1, 32'h404);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        #2 rst_n = 1'b1;
        ex_ready = 1'b1;
        present(I_ADDI_X1_5, 32'h500);
        tick();
        check_val("post_reset_ex_valid", ex_valid, 1);
        check_val("post_reset_ex_pc", ex_pc, 32'h500);
        check_val("post_reset_busy", dut.busy_reg, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter N, default 32, datapath and PC width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_instr  in  32  RV32I instruction word.
REQ-006 if_pc  in  N  PC of if_instr.
REQ-007 if_ready  out  1  id_stage accepts if_instr this cycle.
REQ-008 rf_rs1, rf_rs2  out  5 each  register file read addresses.
REQ-009 rf_rdata1, rf_rdata2  in  N each  combinational register file read data.
REQ-010 wb_we, wb_rd, wb_data  in  1/5/N  write-back port, the same signals that drive the register file write port.
REQ-011 flush  in  1  discard the held instruction and clear the scoreboard.
REQ-012 ex_valid  out  1  output register holds an instruction.
REQ-013 ex_ready  in  1  execute stage consumes the instruction.
REQ-014 ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm  out  N/32/N/N/N  registered decoded payload.
REQ-015 ex_rd, ex_rd_we  out  5/1  destination register and write flag.

Function
REQ-016 rf_rs1 = if_instr[19:15] and rf_rs2 = if_instr[24:20], combinationally, every cycle.
REQ-017 Uses rs1: opcodes JALR, BRANCH, LOAD, STORE, OP-IMM, OP; uses rs2: BRANCH, STORE, OP; writes rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, with rd=0 never counted as a write.
REQ-018 Immediate decoded per I/S/B/U/J format, sign-extended to N bits; 0 for R-type and unknown opcodes.
REQ-019 Scoreboard: 32 busy bits, bit 0 hardwired 0.
REQ-020 Hazard = (uses rs1 and busy[rs1] and not (wb_we and wb_rd==rs1)) or same for rs2 or (writes rd and busy[rd] and not (wb_we and wb_rd==rd)).
REQ-021 if_ready = (!ex_valid or ex_ready) and !hazard and !flush.
REQ-022 Accept (if_valid and if_ready): output register loads pc, instr, operands, imm, rd, rd_we; ex_valid=1; busy[rd] set if writes rd.
REQ-023 Operand bypass: if wb_we and wb_rd==rsX and rsX!=0 then wb_data, else rf_rdataX; rsX=0 always yields 0.
REQ-024 ex_valid and ex_ready with no accept: ex_valid cleared next cycle; with accept: replaced, zero bubbles.
REQ-025 Output payload held stable while ex_valid and !ex_ready.
REQ-026 wb_we with wb_rd!=0 clears busy[wb_rd]; simultaneous set and clear on the same bit: set wins.
REQ-027 flush: ex_valid=0 and all busy bits=0 next cycle, no accept that cycle; flush is asserted only after all older register writes have retired.
REQ-028 Latency: one cycle from accept to ex_valid.

Reset
REQ-029 rst_n low: ex_valid=0, scoreboard all 0, ex_pc/ex_instr/ex_rs1_data/ex_rs2_data/ex_imm/ex_rd=0, ex_rd_we=0, immediately and asynchronously.
REQ-030 Reset mid-operation discards the held instruction with no partial state retained; first accept possible on the first edge after rst_n deasserts.

Structure
REQ-031 Shared package holds the RV32I opcode constants, immediate-format enumeration and the register-index width.
REQ-032 One sub-module, imm_gen (combinational immediate decoder); scoreboard and output register inline.

Verification
REQ-033 Reset, then ADDI x1,x0,5 with rf_rdata1=0, ex_ready=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, busy[1]=1.
REQ-034 ADD x3,x1,x2 while busy[1]=1 and no wb -> if_ready=0; wb_we=1,wb_rd=1,wb_data=0x55 -> accepted that cycle, ex_rs1_data=0x55.
REQ-035 ex_ready=0 for 3 cycles with ex_valid=1 -> payload unchanged, if_ready=0; ex_ready=1 with if_valid -> new instruction next cycle, no bubble.
REQ-036 LW x0,4(x2) -> ex_rd_we=0, busy unchanged, ex_imm=4; SW x5,-8(x2) -> ex_imm=0xFFFFFFF8, ex_rd_we=0.
REQ-037 Two ADDI x4 back to back, no wb -> second stalled (WAW) until wb_rd=4; wb clear and new set same cycle -> busy[4]=1.
REQ-038 flush with ex_valid=1, busy[7]=1 -> next cycle ex_valid=0, all busy 0; rst_n pulse mid-stall -> all outputs 0 asynchronously.
